// File: rtl/bcd_pkg.sv
// Shared constants and FSM encoding for the digit-serial BCD complementer.
package bcd_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [4:0] BCD_TEN = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_digit_nines.sv
// Single-digit 9's complement gate network with a BCD-validity flag.
module bcd_digit_nines
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] nines_o,
  output logic       valid_o
);

  // Gate form of 9-d; only meaningful when the digit is a legal BCD code
  assign nines_o[3] = ~digit_i[3] & ~digit_i[2] & ~digit_i[1];
  assign nines_o[2] = digit_i[2] ^ digit_i[1];
  assign nines_o[1] = digit_i[1];
  assign nines_o[0] = ~digit_i[0];

  assign valid_o = (digit_i <= BCD_MAX);

endmodule

// File: rtl/bcd_complement_seq.sv
// Digit-serial N-digit BCD 9's/10's complementer, LSD first, start/done handshake.
module bcd_complement_seq
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode,
  input  logic [DIGIT_W*DIGITS-1:0] din,
  output logic                      ready,
  output logic                      busy,
  output logic                      done,
  output logic [DIGIT_W*DIGITS-1:0] dout,
  output logic                      cout,
  output logic                      err
);

  localparam int unsigned W     = DIGIT_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     opr_q, opr_d;
  logic [W-1:0]     dout_q, dout_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mode_q, mode_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [3:0] digit_sel;
  logic [3:0] digit_nines;
  logic       digit_valid;
  logic [4:0] digit_sum;
  logic [3:0] digit_res;
  logic       carry_nxt;

  // Select the operand digit addressed by idx
  always_comb begin
    digit_sel = 4'h0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) digit_sel = opr_q[DIGIT_W*i +: DIGIT_W];
    end
  end

  bcd_digit_nines u_nines (
    .digit_i (digit_sel),
    .nines_o (digit_nines),
    .valid_o (digit_valid)
  );

  // Add incoming carry; a sum of ten wraps to zero and ripples on
  always_comb begin
    digit_sum = {1'b0, digit_nines} + {4'b0000, carry_q};
    digit_res = digit_sum[3:0];
    carry_nxt = 1'b0;
    if (!digit_valid) begin
      digit_res = 4'h0;
      carry_nxt = 1'b0;
    end else if (digit_sum == BCD_TEN) begin
      digit_res = 4'h0;
      carry_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      opr_q   <= '0;
      dout_q  <= '0;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      dout_q  <= dout_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    dout_d  = dout_q;
    idx_d   = idx_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    err_d   = err_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          opr_d   = din;
          mode_d  = mode;
          idx_d   = '0;
          carry_d = mode;
          dout_d  = '0;
          cout_d  = 1'b0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (idx_q == IDX_W'(i)) dout_d[DIGIT_W*i +: DIGIT_W] = digit_res;
        end
        idx_d   = idx_q + IDX_W'(1);
        carry_d = carry_nxt;
        if (!digit_valid) err_d = 1'b1;
        if (idx_q == IDX_LAST) begin
          cout_d  = mode_q & carry_nxt;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they align with state_q
  assign ready_d = (state_d != ST_RUN);
  assign busy_d  = (state_d == ST_RUN);
  assign done_d  = (state_d == ST_DONE);

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dout  = dout_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_complement_seq.sv
// Directed self-checking bench for bcd_complement_seq with an expected-result scoreboard.
module tb_bcd_complement_seq;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct packed {
    logic [W-1:0] dout;
    logic         cout;
    logic         err;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic         mode;
  logic [W-1:0] din;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] dout;
  logic         cout;
  logic         err;

  exp_t sb[$];
  int   checks;
  int   failures;

  bcd_complement_seq #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .din   (din),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .dout  (dout),
    .cout  (cout),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [W-1:0] d, input logic m);
    exp_t e;
    int   c;
    int   v;
    int   s;
    e.dout = '0;
    e.err  = 1'b0;
    c = int'(m);
    for (int i = 0; i < int'(DIGITS); i++) begin
      v = int'(d[4*i +: 4]);
      if (v > 9) begin
        e.dout[4*i +: 4] = 4'h0;
        e.err = 1'b1;
        c = 0;
      end else begin
        s = 9 - v + c;
        if (s == 10) begin
          e.dout[4*i +: 4] = 4'h0;
          c = 1;
        end else begin
          e.dout[4*i +: 4] = 4'(s);
          c = 0;
        end
      end
    end
    e.cout = m & (c == 1);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request for one edge starting just after a rising edge; expectation goes to the scoreboard
  task automatic launch(input logic [W-1:0] d, input logic m);
    start = 1'b1;
    din   = d;
    mode  = m;
    sb.push_back(model(d, m));
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done, then score the result against the oldest expectation
  task automatic wait_done(input string tag, input int lat);
    int   n;
    bit   got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (n < lat + 6 && !got) begin
      @(posedge clk);
      #1;
      n++;
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, " latency"}, 32'(n), 32'(lat));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (got) begin
        check({tag, " dout"}, 32'(dout), 32'(e.dout));
        check({tag, " cout"}, 32'(cout), 32'(e.cout));
        check({tag, " err"},  32'(err),  32'(e.err));
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " busy"},  32'(busy),  32'd0);
      end
    end
  endtask

  task automatic after_done(input string tag);
    @(posedge clk);
    #1;
    check({tag, " done drop"}, 32'(done), 32'd0);
    check({tag, " idle ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = 1'b0;
    din   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst ready", 32'(ready), 32'd1);
    check("rst busy",  32'(busy),  32'd0);
    check("rst done",  32'(done),  32'd0);
    check("rst dout",  32'(dout),  32'd0);
    check("rst cout",  32'(cout),  32'd0);
    check("rst err",   32'(err),   32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Basic 9's complement, known answer plus scoreboard
    launch(16'h0123, 1'b0);
    check("t1 busy", 32'(busy), 32'd1);
    check("t1 ready", 32'(ready), 32'd0);
    wait_done("t1", DIGITS);
    check("t1 known", 32'(dout), 32'h9876);
    after_done("t1");

    launch(16'h0123, 1'b1);
    wait_done("t2", DIGITS);
    check("t2 known", 32'(dout), 32'h9877);
    after_done("t2");

    launch(16'h1000, 1'b1);
    wait_done("t3a", DIGITS);
    check("t3a known", 32'(dout), 32'h9000);
    check("t3a cout", 32'(cout), 32'd0);
    after_done("t3a");

    launch(16'h0000, 1'b1);
    wait_done("t3b", DIGITS);
    check("t3b known", 32'(dout), 32'h0000);
    check("t3b cout", 32'(cout), 32'd1);
    after_done("t3b");

    // All-zero operand in 9's mode must not produce a carry
    launch(16'h0000, 1'b0);
    wait_done("t3c", DIGITS);
    check("t3c known", 32'(dout), 32'h9999);
    after_done("t3c");

    launch(16'h12A4, 1'b0);
    wait_done("t4a", DIGITS);
    check("t4a known", 32'(dout), 32'h8705);
    check("t4a err", 32'(err), 32'd1);
    after_done("t4a");
    check("t4a err hold", 32'(err), 32'd1);

    launch(16'h0009, 1'b0);
    check("t4b err clear", 32'(err), 32'd0);
    wait_done("t4b", DIGITS);
    check("t4b known", 32'(dout), 32'h9990);
    after_done("t4b");

    // Invalid digit in 10's mode kills the carry chain
    launch(16'hF000, 1'b1);
    wait_done("t4c", DIGITS);
    check("t4c known", 32'(dout), 32'h0000);
    check("t4c cout", 32'(cout), 32'd0);
    after_done("t4c");

    // Start while busy is ignored; din/mode changes mid-run have no effect
    launch(16'h0123, 1'b0);
    @(posedge clk);
    #1;
    start = 1'b1;
    din   = 16'h5555;
    mode  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t5a", DIGITS - 2);
    // Back-to-back request in the done cycle
    launch(16'h4567, 1'b1);
    check("t5b done drop", 32'(done), 32'd0);
    check("t5b busy", 32'(busy), 32'd1);
    wait_done("t5b", DIGITS);
    check("t5b known", 32'(dout), 32'h5433);
    after_done("t5b");

    // Reset two edges into a run
    launch(16'h00A0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("t6 partial dout", 32'(dout), 32'h0009);
    check("t6 partial err", 32'(err), 32'd1);
    rst = 1'b1;
    #1;
    check("t6 rst dout",  32'(dout),  32'd0);
    check("t6 rst err",   32'(err),   32'd0);
    check("t6 rst busy",  32'(busy),  32'd0);
    check("t6 rst ready", 32'(ready), 32'd1);
    void'(sb.pop_back());
    repeat (3) begin
      @(posedge clk);
      #1;
      check("t6 no done", 32'(done), 32'd0);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("t6 idle done", 32'(done), 32'd0);
    launch(16'h9081, 1'b1);
    wait_done("t6", DIGITS);
    after_done("t6");

    // A few random operands through the scoreboard
    for (int k = 0; k < 6; k++) begin
      launch(16'($urandom_range(0, 32'hFFFF)), 1'($urandom_range(0, 1)));
      wait_done("rnd", DIGITS);
    end
    after_done("rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
